data_mem_unit: RTL and testbench

Load/store stage directly downstream of the RV32I ALU. It takes the ALU result as the effective byte address and executes RV32I loads and stores against an internal word-organised data RAM. Stores commit on the clock edge. Load data is produced combinationally in the same cycle, with byte/halfword extraction and sign or zero extension, so the single-cycle datapath can write it back. Misaligned and out-of-range accesses are suppressed, flagged immediately, and recorded in a sticky fault register for debug and trap logic.

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_byte_ram.sv | 26 ++
 rtl/data_mem_unit.sv | 132 +++++++++++++
 tb/tb_data_mem_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared funct3 encodings and lane helpers for the data memory stage.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-lane write enables for a store of the given width at the given lane.
  function automatic logic [3:0] store_byte_en(input logic [2:0] funct,
                                               input logic [1:0] lane);
    logic [3:0] be;
    case (funct)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = 4'b0011 << {lane[1], 1'b0};
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Select the addressed byte/halfword from a RAM word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0]  funct,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h00_0000, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0000, h};
      F3_W:    r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM: synchronous per-byte write, asynchronous read, no reset.
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Per-lane store commit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/data_mem_unit.sv
// RV32I load/store stage: access checks, lane steering, load extension and
// a sticky first-fault record.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MisAlign,
  output logic        FaultValid,
  output logic [31:0] FaultAddr,
  output logic        FaultIsStore,
  input  logic        FaultClear
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0]   offset_s;
  logic [AW-1:0] word_idx_s;
  logic          in_range_s;
  logic          misaligned_s;
  logic          illegal_s;
  logic          mis_align_s;
  logic [3:0]    ram_we_s;
  logic [31:0]   store_data_s;
  logic [31:0]   ram_rdata_s;
  logic [31:0]   read_data_s;
  logic          fault_valid_r;
  logic [31:0]   fault_addr_r;
  logic          fault_is_store_r;

  // Range, alignment and funct legality of the current access.
  always_comb begin
    offset_s   = Addr - BASE_ADDR;
    in_range_s = ({1'b0, offset_s} < SPAN_BYTES);
    word_idx_s = offset_s[AW+1:2];
    case (funct)
      F3_B: begin
        misaligned_s = 1'b0;
        illegal_s    = 1'b0;
      end
      F3_BU: begin
        misaligned_s = 1'b0;
        illegal_s    = MemWrite;
      end
      F3_H: begin
        misaligned_s = Addr[0];
        illegal_s    = 1'b0;
      end
      F3_HU: begin
        misaligned_s = Addr[0];
        illegal_s    = MemWrite;
      end
      F3_W: begin
        misaligned_s = (Addr[1:0] != 2'b00);
        illegal_s    = 1'b0;
      end
      default: begin
        misaligned_s = 1'b0;
        illegal_s    = 1'b1;
      end
    endcase
    mis_align_s = (MemRead | MemWrite) & (misaligned_s | ~in_range_s | illegal_s);
  end

  // Store lane steering; writes are dropped on faults and while in reset.
  always_comb begin
    case (funct)
      F3_B:    store_data_s = {4{WriteData[7:0]}};
      F3_H:    store_data_s = {2{WriteData[15:0]}};
      default: store_data_s = WriteData;
    endcase
    if (MemWrite && !mis_align_s && !rst) begin
      ram_we_s = store_byte_en(funct, Addr[1:0]);
    end else begin
      ram_we_s = 4'b0000;
    end
  end

  dmem_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .addr (word_idx_s),
    .wdata(store_data_s),
    .rdata(ram_rdata_s)
  );

  // Load path reads pre-store contents, so a same-cycle store is not visible.
  always_comb begin
    if (MemRead && !mis_align_s) begin
      read_data_s = load_extract(funct, Addr[1:0], ram_rdata_s);
    end else begin
      read_data_s = 32'h0000_0000;
    end
  end

  // Sticky first-fault record; a clear beats a coincident fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_valid_r    <= 1'b0;
      fault_addr_r     <= 32'h0000_0000;
      fault_is_store_r <= 1'b0;
    end else if (FaultClear) begin
      fault_valid_r    <= 1'b0;
      fault_addr_r     <= 32'h0000_0000;
      fault_is_store_r <= 1'b0;
    end else if (mis_align_s && !fault_valid_r) begin
      fault_valid_r    <= 1'b1;
      fault_addr_r     <= Addr;
      fault_is_store_r <= MemWrite;
    end
  end

  assign ReadData     = read_data_s;
  assign MisAlign     = mis_align_s;
  assign FaultValid   = fault_valid_r;
  assign FaultAddr    = fault_addr_r;
  assign FaultIsStore = fault_is_store_r;

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomized bench for data_mem_unit against a byte-array reference model.
module tb_data_mem_unit;
  import dmem_pkg::*;

  localparam logic [31:0] TB_BASE  = 32'h0000_0000;
  localparam int          TB_BYTES = 4096;

  logic        clk, rst, MemRead, MemWrite, FaultClear;
  logic [2:0]  funct;
  logic [31:0] Addr, WriteData, ReadData, FaultAddr;
  logic        MisAlign, FaultValid, FaultIsStore;

  int   checks = 0;
  int   errors = 0;
  bit   cmp_en;

  logic [7:0]  mdl_mem [TB_BYTES];
  logic        m_fv, m_fs;
  logic [31:0] m_fa;

  data_mem_unit #(.DEPTH_WORDS(1024), .BASE_ADDR(TB_BASE)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct(funct), .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .MisAlign(MisAlign), .FaultValid(FaultValid), .FaultAddr(FaultAddr),
    .FaultIsStore(FaultIsStore), .FaultClear(FaultClear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_size(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_fault(input logic r, input logic w, input logic [2:0] f,
                                 input logic [31:0] a);
    int sz;
    if (!(r || w)) return 1'b0;
    sz = m_size(f);
    if (sz == 0 || (w && f[2])) return 1'b1;
    if ((a % 32'(sz)) != 32'd0) return 1'b1;
    return !((a - TB_BASE) < 32'(TB_BYTES));
  endfunction

  function automatic logic [31:0] m_read(input logic r, input logic w, input logic [2:0] f,
                                         input logic [31:0] a);
    int          sz;
    int unsigned off;
    logic [31:0] v;
    if (!r || m_fault(r, w, f, a)) return 32'h0;
    sz  = m_size(f);
    off = a - TB_BASE;
    v   = 32'h0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = mdl_mem[off+i];
    if (!f[2] && sz < 4 && mdl_mem[off+sz-1][7])
      for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Reference state update at each edge.
  always @(posedge clk) begin
    if (rst) begin
      m_fv <= 1'b0; m_fa <= 32'h0; m_fs <= 1'b0;
    end else begin
      if (MemWrite && !m_fault(MemRead, MemWrite, funct, Addr))
        for (int i = 0; i < m_size(funct); i++)
          mdl_mem[(Addr - TB_BASE) + 32'(i)] <= WriteData[8*i +: 8];
      if (FaultClear) begin
        m_fv <= 1'b0; m_fa <= 32'h0; m_fs <= 1'b0;
      end else if (m_fault(MemRead, MemWrite, funct, Addr) && !m_fv) begin
        m_fv <= 1'b1; m_fa <= Addr; m_fs <= MemWrite;
      end
    end
  end

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("MisAlign", {31'd0, MisAlign}, {31'd0, m_fault(MemRead, MemWrite, funct, Addr)});
      chk("ReadData", ReadData, m_read(MemRead, MemWrite, funct, Addr));
      chk("FaultValid", {31'd0, FaultValid}, rst ? 32'd0 : {31'd0, m_fv});
      chk("FaultAddr", FaultAddr, rst ? 32'd0 : m_fa);
      chk("FaultIsStore", {31'd0, FaultIsStore}, rst ? 32'd0 : {31'd0, m_fs});
    end
  end

  task automatic drive(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] wd, input logic fc);
    @(posedge clk); #1;
    MemRead = r; MemWrite = w; funct = f; Addr = a; WriteData = wd; FaultClear = fc;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  logic [2:0]  legal_f [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
  logic [1:0]  op_v;
  logic [2:0]  f_v;
  logic [31:0] a_v;

  initial begin
    clk = 1'b0; rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct = 3'd0;
    Addr = 32'h0; WriteData = 32'h0; FaultClear = 1'b0; cmp_en = 1'b1;
    m_fv = 1'b0; m_fa = 32'h0; m_fs = 1'b0;
    #1 rst = 1'b1;
    settle();
    chk("reset_fv", {31'd0, FaultValid}, 32'd0);
    chk("reset_fa", FaultAddr, 32'd0);
    chk("reset_fs", {31'd0, FaultIsStore}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 1024; i++) drive(1'b0, 1'b1, F3_W, 32'(i*4), $urandom, 1'b0);

    // Word store/load
    drive(1'b0, 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 1'b0);
    drive(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b0);
    settle();
    chk("lw_10", ReadData, 32'hDEAD_BEEF);
    chk("lw_10_ma", {31'd0, MisAlign}, 32'd0);

    // Byte store and extension
    drive(1'b0, 1'b1, F3_B, 32'h13, 32'h0000_0080, 1'b0);
    drive(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b0);
    settle(); chk("lw_after_sb", ReadData, 32'h80AD_BEEF);
    drive(1'b1, 1'b0, F3_B, 32'h13, 32'h0, 1'b0);
    settle(); chk("lb_13", ReadData, 32'hFFFF_FF80);
    drive(1'b1, 1'b0, F3_BU, 32'h13, 32'h0, 1'b0);
    settle(); chk("lbu_13", ReadData, 32'h0000_0080);

    // Halfword
    drive(1'b0, 1'b1, F3_W, 32'h20, 32'h1111_5A5A, 1'b0);
    drive(1'b0, 1'b1, F3_H, 32'h22, 32'h0000_8001, 1'b0);
    drive(1'b1, 1'b0, F3_H, 32'h22, 32'h0, 1'b0);
    settle(); chk("lh_22", ReadData, 32'hFFFF_8001);
    drive(1'b1, 1'b0, F3_HU, 32'h22, 32'h0, 1'b0);
    settle(); chk("lhu_22", ReadData, 32'h0000_8001);
    drive(1'b1, 1'b0, F3_H, 32'h20, 32'h0, 1'b0);
    settle(); chk("lh_20", ReadData, 32'h0000_5A5A);

    // Misaligned store and sticky fault
    drive(1'b0, 1'b1, F3_W, 32'h14, 32'h0BAD_F00D, 1'b0);
    drive(1'b0, 1'b1, F3_W, 32'h15, 32'hFFFF_FFFF, 1'b0);
    settle(); chk("sw_15_ma", {31'd0, MisAlign}, 32'd1);
    drive(1'b1, 1'b0, F3_W, 32'h14, 32'h0, 1'b0);
    settle();
    chk("ram_unchanged", ReadData, 32'h0BAD_F00D);
    chk("fv_15", {31'd0, FaultValid}, 32'd1);
    chk("fa_15", FaultAddr, 32'h15);
    chk("fs_15", {31'd0, FaultIsStore}, 32'd1);
    drive(1'b1, 1'b0, F3_H, 32'h31, 32'h0, 1'b0);
    settle(); chk("lh_31_ma", {31'd0, MisAlign}, 32'd1);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b0);
    settle(); chk("fa_kept", FaultAddr, 32'h15);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b0);
    settle();
    chk("clr_fv", {31'd0, FaultValid}, 32'd0);
    chk("clr_fa", FaultAddr, 32'd0);
    chk("clr_fs", {31'd0, FaultIsStore}, 32'd0);

    // Clear beats a coincident fault
    drive(1'b1, 1'b0, F3_W, 32'h11, 32'h0, 1'b1);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b0);
    settle(); chk("clr_wins", {31'd0, FaultValid}, 32'd0);

    // Out of range, then asynchronous reset and a dropped store
    drive(1'b1, 1'b0, F3_W, 32'h1000, 32'h0, 1'b0);
    settle();
    chk("oor_rd", ReadData, 32'h0);
    chk("oor_ma", {31'd0, MisAlign}, 32'd1);
    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b0);
    #1 chk("oor_fv", {31'd0, FaultValid}, 32'd1);
    rst = 1'b1; MemWrite = 1'b1; Addr = 32'h10; WriteData = 32'h5555_5555;
    #1 chk("rst_async_fv", {31'd0, FaultValid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; MemWrite = 1'b0; MemRead = 1'b1; funct = F3_W; Addr = 32'h10;
    settle(); chk("rst_store_dropped", ReadData, 32'h80AD_BEEF);

    // Read-before-write on a simultaneous access
    drive(1'b0, 1'b1, F3_W, 32'h40, 32'hAAAA_AAAA, 1'b0);
    drive(1'b1, 1'b1, F3_W, 32'h40, 32'h1234_5678, 1'b0);
    settle(); chk("rbw_old", ReadData, 32'hAAAA_AAAA);
    drive(1'b1, 1'b0, F3_W, 32'h40, 32'h0, 1'b0);
    settle(); chk("rbw_new", ReadData, 32'h1234_5678);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      op_v = 2'($urandom_range(0, 3));
      f_v  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legal_f[$urandom_range(0, 4)];
      a_v  = 32'($urandom_range(0, TB_BYTES - 1));
      case ($urandom_range(0, 2))
        0: a_v[1:0] = 2'b00;
        1: a_v[0]   = 1'b0;
        default: a_v = a_v;
      endcase
      if ($urandom_range(0, 11) == 0) a_v = 32'h1000 + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) a_v = $urandom;
      drive(op_v[0], op_v[1], f_v, TB_BASE + a_v, $urandom,
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b0);
    settle();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
